// File: rtl/seg7_capture_if.sv
// Bus between a multiplexed 7-segment display driver and the capture block.
// Observed side (seg_data/dig_sel/capture_en) comes from the master; decoded results come back from the slave.
interface seg7_capture_if #(
    parameter int DIGITS = 6
);
    // No valid/ready handshake: upd_pulse qualifies digit_val/digit_vld for exactly one
    // cycle after each commit, err_pulse marks a rejected window, and the value
    // registers hold between pulses so they may be read at any time.
    logic [6:0]          seg_data;
    logic [DIGITS-1:0]   dig_sel;
    logic                capture_en;
    logic [4*DIGITS-1:0] digit_val;
    logic [DIGITS-1:0]   digit_vld;
    logic                upd_pulse;
    logic                err_pulse;
    logic [7:0]          err_cnt;
    logic                fsm_state;

    modport master (
        output seg_data, dig_sel, capture_en,
        input  digit_val, digit_vld, upd_pulse, err_pulse, err_cnt, fsm_state
    );

    modport slave (
        input  seg_data, dig_sel, capture_en,
        output digit_val, digit_vld, upd_pulse, err_pulse, err_cnt, fsm_state
    );
endinterface

// File: rtl/seg7_capture.sv
// Reads back a multiplexed active-low 7-segment bus: waits for each digit pattern
// to be stable, decodes it to hex and keeps one value register per digit.
module seg7_capture #(
    parameter int DIGITS        = 6,
    parameter int STABLE_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    seg7_capture_if.slave bus
);
    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

    state_t              state;
    logic [DIGITS+6:0]   in_q;
    logic [7:0]          cnt;
    logic [4*DIGITS-1:0] val_q;
    logic [DIGITS-1:0]   vld_q;
    logic                upd_q;
    logic                err_q;
    logic [7:0]          err_cnt_q;

    logic [DIGITS+6:0]   live;
    logic                same;
    logic [7:0]          cnt_nxt;
    logic [DIGITS-1:0]   sel_n;
    logic [6:0]          glyph;
    logic [4:0]          dec;
    logic                one_sel;
    logic                multi_sel;
    logic                blank;
    logic                commit;
    logic                do_upd;
    logic                do_err;

    // Returns {hit, value} for the sixteen encoder glyphs (bit0=a .. bit6=g, active-high).
    function automatic logic [4:0] decode_glyph(input logic [6:0] g);
        case (g)
            7'h3F:   return {1'b1, 4'h0};
            7'h06:   return {1'b1, 4'h1};
            7'h5B:   return {1'b1, 4'h2};
            7'h4F:   return {1'b1, 4'h3};
            7'h66:   return {1'b1, 4'h4};
            7'h6D:   return {1'b1, 4'h5};
            7'h7D:   return {1'b1, 4'h6};
            7'h07:   return {1'b1, 4'h7};
            7'h7F:   return {1'b1, 4'h8};
            7'h6F:   return {1'b1, 4'h9};
            7'h77:   return {1'b1, 4'hA};
            7'h7C:   return {1'b1, 4'hB};
            7'h39:   return {1'b1, 4'hC};
            7'h5E:   return {1'b1, 4'hD};
            7'h79:   return {1'b1, 4'hE};
            7'h71:   return {1'b1, 4'hF};
            default: return 5'b0;
        endcase
    endfunction

    always_comb begin
        live  = {bus.dig_sel, bus.seg_data};
        same  = (live == in_q);
        if (!same)
            cnt_nxt = 8'd0;
        else if (cnt == STABLE_MAX)
            cnt_nxt = cnt;
        else
            cnt_nxt = cnt + 8'd1;
        sel_n     = ~bus.dig_sel;
        glyph     = ~bus.seg_data;
        dec       = decode_glyph(glyph);
        one_sel   = $onehot(sel_n);
        multi_sel = !$onehot0(sel_n);
        blank     = (glyph == 7'd0);
        // A change landing on the would-be commit edge clears same and so blocks the commit.
        commit    = bus.capture_en && (state == ST_WAIT) && same && (cnt_nxt == STABLE_MAX);
        do_upd    = commit && one_sel && (dec[4] || blank);
        do_err    = commit && (multi_sel || (one_sel && !dec[4] && !blank));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_WAIT;
            in_q      <= '1;
            cnt       <= 8'd0;
            val_q     <= '0;
            vld_q     <= '0;
            upd_q     <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            in_q  <= live;
            upd_q <= do_upd;
            err_q <= do_err;
            if (do_err && (err_cnt_q != 8'hFF))
                err_cnt_q <= err_cnt_q + 8'd1;
            if (commit && one_sel) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (sel_n[i]) begin
                        vld_q[i] <= dec[4];
                        if (dec[4])
                            val_q[4*i +: 4] <= dec[3:0];
                    end
                end
            end
            if (!bus.capture_en) begin
                state <= ST_WAIT;
                cnt   <= 8'd0;
            end else begin
                cnt <= cnt_nxt;
                case (state)
                    ST_WAIT: if (commit) state <= ST_HOLD;
                    ST_HOLD: if (!same) state <= ST_WAIT;
                    default: state <= ST_WAIT;
                endcase
            end
        end
    end

    assign bus.digit_val = val_q;
    assign bus.digit_vld = vld_q;
    assign bus.upd_pulse = upd_q;
    assign bus.err_pulse = err_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.fsm_state = (state == ST_HOLD);
endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: a run-length model of the sampled bus predicts
// every output each cycle, and literal checks pin the model at key points.
module tb_seg7_capture;
    localparam int DIGITS = 6;
    localparam int STABLE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seg7_capture_if #(.DIGITS(DIGITS)) bus();

    seg7_capture #(
        .DIGITS        (DIGITS),
        .STABLE_CYCLES (STABLE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [6:0] scan_g [6] = '{7'h06, 7'h5B, 7'h4F, 7'h77, 7'h7C, 7'h71};

    // Model state: per-digit values, run length of identical enabled samples.
    logic [3:0]          m_val [DIGITS];
    logic [DIGITS-1:0]   m_vld;
    logic                m_upd;
    logic                m_err;
    int                  m_err_cnt;
    logic [DIGITS+6:0]   m_prev;
    int                  streak;
    logic [4*DIGITS-1:0] exp_q [$];
    int                  upd_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [4*DIGITS-1:0] pack_val();
        logic [4*DIGITS-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = m_val[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DIGITS; i++) m_val[i] = 4'h0;
        m_vld     = '0;
        m_upd     = 1'b0;
        m_err     = 1'b0;
        m_err_cnt = 0;
        m_prev    = '1;
        streak    = 0;
        exp_q.delete();
    endtask

    task automatic model_commit(input logic [DIGITS-1:0] sel, input logic [6:0] seg);
        int lows = 0;
        int k = 0;
        int v = -1;
        logic [6:0] g;
        for (int i = 0; i < DIGITS; i++) if (!sel[i]) begin lows++; k = i; end
        g = ~seg;
        if (lows > 1) begin
            m_err = 1'b1;
        end else if (lows == 1) begin
            for (int j = 0; j < 16; j++) if (glyph_tab[j] == g) v = j;
            if (v >= 0) begin
                m_val[k] = v[3:0];
                m_vld[k] = 1'b1;
                m_upd    = 1'b1;
            end else begin
                m_vld[k] = 1'b0;
                if (g == 7'd0) m_upd = 1'b1;
                else           m_err = 1'b1;
            end
        end
        if (m_err && m_err_cnt < 255) m_err_cnt++;
        if (m_upd) exp_q.push_back(pack_val());
    endtask

    // Model: a commit happens on the edge where the run of identical, enabled samples reaches STABLE.
    initial begin
        logic [DIGITS+6:0] s;
        model_reset();
        forever begin
            @(posedge clk);
            if (rst) begin
                model_reset();
            end else begin
                s     = {bus.dig_sel, bus.seg_data};
                m_upd = 1'b0;
                m_err = 1'b0;
                if (!bus.capture_en || s != m_prev) streak = 0;
                else                                streak++;
                m_prev = s;
                if (streak == STABLE) model_commit(bus.dig_sel, bus.seg_data);
            end
        end
    end

    // Compare process.
    initial begin
        forever begin
            @(negedge clk);
            check("digit_val", 32'(bus.digit_val), 32'(pack_val()));
            check("digit_vld", 32'(bus.digit_vld), 32'(m_vld));
            check("upd_pulse", 32'(bus.upd_pulse), 32'(m_upd));
            check("err_pulse", 32'(bus.err_pulse), 32'(m_err));
            check("err_cnt",   32'(bus.err_cnt),   32'(m_err_cnt));
            if (bus.upd_pulse) begin
                upd_seen++;
                if (exp_q.size() > 0) begin
                    check("upd_snapshot", 32'(bus.digit_val), 32'(exp_q.pop_front()));
                end else begin
                    total++;
                    bad++;
                    $display("FAIL upd_unexpected: got pulse want none");
                end
            end
        end
    end

    task automatic show(input logic [DIGITS-1:0] sel, input logic [6:0] g, input int n);
        bus.dig_sel  = sel;
        bus.seg_data = ~g;
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        int base;
        logic [DIGITS-1:0] sel;
        bus.dig_sel    = '1;
        bus.seg_data   = '1;
        bus.capture_en = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_val", 32'(bus.digit_val), 32'h0);
        check("rst_vld", 32'(bus.digit_vld), 32'h0);
        check("rst_err_cnt", 32'(bus.err_cnt), 32'h0);
        check("rst_upd", 32'(bus.upd_pulse), 32'h0);

        // Single glyph '2' on digit 0: commit after edge 4, once only.
        rst = 1'b0;
        base = upd_seen;
        bus.dig_sel  = 6'b111110;
        bus.seg_data = ~7'h5B;
        repeat (4) @(negedge clk);
        #1 check("t1_no_early_upd", 32'(bus.upd_pulse), 32'h0);
        @(negedge clk);
        #1;
        check("t1_upd", 32'(bus.upd_pulse), 32'h1);
        check("t1_val0", 32'(bus.digit_val[3:0]), 32'h2);
        check("t1_vld0", 32'(bus.digit_vld[0]), 32'h1);
        repeat (20) @(negedge clk);
        #1 check("t1_one_pulse", 32'(upd_seen - base), 32'h1);

        // Scan all digits.
        base = upd_seen;
        for (int i = 0; i < DIGITS; i++) begin
            sel = '1;
            sel[i] = 1'b0;
            show(sel, scan_g[i], 8);
            show('1, 7'h00, 2);
        end
        check("t2_val", 32'(bus.digit_val), 32'hFBA321);
        check("t2_vld", 32'(bus.digit_vld), 32'h3F);
        check("t2_err_cnt", 32'(bus.err_cnt), 32'h0);
        check("t2_upds", 32'(upd_seen - base), 32'h6);

        // Too-short window, then an illegal glyph on digit 2.
        base = upd_seen;
        show(6'b110111, 7'h07, 4);
        show('1, 7'h00, 2);
        check("t3_short_no_upd", 32'(upd_seen - base), 32'h0);
        check("t3_short_val", 32'(bus.digit_val), 32'hFBA321);
        show(6'b111011, 7'h01, 8);
        show('1, 7'h00, 2);
        check("t3_err_cnt", 32'(bus.err_cnt), 32'h1);
        check("t3_vld2", 32'(bus.digit_vld[2]), 32'h0);
        check("t3_val2", 32'(bus.digit_val[11:8]), 32'h3);

        // Two-digit select errors up to saturation.
        show(6'b111100, 7'h06, 8);
        show('1, 7'h00, 2);
        check("t4_err_cnt", 32'(bus.err_cnt), 32'h2);
        check("t4_val", 32'(bus.digit_val), 32'hFBA321);
        for (int w = 0; w < 299; w++) begin
            show(6'b111100, 7'h06, 8);
            show('1, 7'h00, 2);
        end
        check("t4_sat", 32'(bus.err_cnt), 32'hFF);

        // Frozen while disabled; re-enable mid-glyph commits on the 4th edge.
        base = upd_seen;
        bus.capture_en = 1'b0;
        show(6'b111110, 7'h7F, 8);
        show(6'b111101, 7'h6F, 8);
        check("t5_frozen_val", 32'(bus.digit_val), 32'hFBA321);
        check("t5_frozen_vld", 32'(bus.digit_vld), 32'h3B);
        check("t5_no_upd", 32'(upd_seen - base), 32'h0);
        check("t5_err_cnt", 32'(bus.err_cnt), 32'hFF);
        bus.dig_sel  = 6'b101111;
        bus.seg_data = ~7'h79;
        repeat (6) @(negedge clk);
        #1 bus.capture_en = 1'b1;
        repeat (3) @(negedge clk);
        #1 check("t5_no_early_upd", 32'(bus.upd_pulse), 32'h0);
        @(negedge clk);
        #1;
        check("t5_upd", 32'(bus.upd_pulse), 32'h1);
        check("t5_val4", 32'(bus.digit_val[19:16]), 32'hE);
        show('1, 7'h00, 2);

        // Reset two edges before a commit.
        bus.dig_sel  = 6'b011111;
        bus.seg_data = ~7'h39;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_val", 32'(bus.digit_val), 32'h0);
        check("t6_rst_vld", 32'(bus.digit_vld), 32'h0);
        check("t6_rst_err_cnt", 32'(bus.err_cnt), 32'h0);
        check("t6_rst_upd", 32'(bus.upd_pulse), 32'h0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        base = upd_seen;
        repeat (4) @(negedge clk);
        #1 check("t6_no_early_upd", 32'(upd_seen - base), 32'h0);
        @(negedge clk);
        #1;
        check("t6_upd", 32'(bus.upd_pulse), 32'h1);
        check("t6_val5", 32'(bus.digit_val[23:20]), 32'hC);
        check("t6_vld", 32'(bus.digit_vld), 32'h20);
        show('1, 7'h00, 2);

        check("exp_q_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seg7_capture.md
Name: seg7_capture

Overview:
- Receive-side counterpart of the hex-to-7-segment encoder.
- Samples the multiplexed, active-low segment/digit-select bus driving the display and waits for each digit's pattern to be stable.
- Decodes each stable pattern back to a 4-bit hex value and holds one value register per digit.
- Used for display self-test and for on-chip readback of the score and timer digits in the game.

Parameters:
- DIGITS, 6, number of multiplexed digits (digit-select width).
- STABLE_CYCLES, 4, consecutive matching samples required before a pattern is committed (range 1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- seg_data  in  7  segment lines, active-low (bit0=a … bit6=g); all-ones means blank.
- dig_sel  in  DIGITS  digit enables, active-low; exactly one low means a digit is being driven.
- capture_en  in  1  high enables capture; low freezes all outputs.
- digit_val  out  4*DIGITS  decoded value of digit i in bits [4i+3:4i].
- digit_vld  out  DIGITS  digit i last committed a legal hex glyph.
- upd_pulse  out  1  one-cycle strobe on each successful commit.
- err_pulse  out  1  one-cycle strobe on an illegal glyph or illegal select.
- err_cnt  out  8  saturating error count.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is asynchronous and active-high, named rst.
  - Reset values: digit_val=0, digit_vld=0, upd_pulse=0, err_pulse=0, err_cnt=0, in_q={all ones}, cnt=0, state=WAIT.
  - Assertion of rst mid-operation clears everything immediately; there is no partial commit.
- Sampling:
  - in_q registers {dig_sel, seg_data} every edge.
  - same = (live inputs == in_q).
  - cnt: if !same then 0; else saturating increment up to STABLE_CYCLES.
- State machine (2 states):
  - WAIT: when same and cnt reaches STABLE_CYCLES (i.e., the pattern is present at STABLE_CYCLES+1 consecutive edges, counting the load edge), perform the commit action and go to HOLD.
  - HOLD: stay while same. On !same, go to WAIT (cnt=0). Only one commit per stable window.
- Commit action (registered, visible after the commit edge):
  - dig_sel all ones (inter-digit blanking): no update, no error; still go to HOLD.
  - dig_sel with more than one low bit: err_pulse=1; err_cnt+1.
  - Exactly one low bit k: decode ~seg_data against the 16 standard glyphs (0,1,2,3,4,5,6,7,8,9,A,b,C,d,E,F in encoder order; '6'=7'b1111101, '8'=7'b1111111).
    - Match: digit_val[k]=value, digit_vld[k]=1, upd_pulse=1.
    - ~seg_data==0 (blank digit): digit_vld[k]=0, digit_val[k] unchanged, upd_pulse=1.
    - Any other pattern: digit_vld[k]=0, digit_val[k] unchanged, err_pulse=1, err_cnt+1.
- Pulses are high for exactly one cycle; otherwise 0.
- err_cnt saturates at 255; no wrap.
- capture_en=0:
  - state forced to WAIT and cnt=0 every cycle.
  - in_q keeps sampling.
  - Outputs hold their values; no pulses.
  - On re-enable, a full STABLE_CYCLES window is required before the next commit.
- A change of input exactly on the commit edge (same=0) suppresses the commit.

Test Plan:
- STABLE_CYCLES=4; dig_sel=6'b111110, seg_data=~7'b1011011 applied before edge 0 and held → after edge 4: digit_val[3:0]=2, digit_vld[0]=1, upd_pulse high for one cycle. Holding 20 more cycles gives no further pulse.
- Scan digits 0..5 with glyphs 1,2,3,A,b,F (each held 8 cycles, 2 blank cycles between) → digit_val=24'hFBA321, digit_vld=6'h3F, six upd_pulses, err_cnt=0.
- Glyph held for only 4 edges (0..3), then changed → no commit, no pulse. Illegal pattern ~7'b0000001 on digit 2 held 8 cycles → err_pulse once, err_cnt=1, digit_vld[2]=0, digit_val[11:8] unchanged.
- dig_sel=6'b111100 held 8 cycles → err_pulse once, no digit_val change. 300 such windows → err_cnt=255 and stays at 255.
- capture_en=0 while scanning new glyphs → outputs frozen. Re-enable mid-glyph → commit occurs 4 edges after re-enable.
- rst asserted 2 cycles before an expected commit → all outputs 0 immediately, no upd_pulse after release until a fresh stable window.
